// File: rtl/regfile_alu.sv
// 32-entry, 2R/1W register file feeding a 4-op combinational ALU.
// Optional write-to-read forwarding is enabled with the RF_BYPASS_EN macro.
module regfile_alu #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      A1,
  input  logic [4:0]      A2,
  input  logic [4:0]      A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            WE3,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic [1:0]      ALUControl,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero
);

  logic [NREGS-1:0][XLEN-1:0] regs_q;
  logic [NREGS-1:0][XLEN-1:0] regs_d;
  logic [XLEN-1:0]            rd1_raw, rd2_raw;

  // Entry 0 is never loaded, so it stays hard-wired to zero.
  always_comb begin
    regs_d    = regs_q;
    regs_d[0] = '0;
    if (WE3 && (A3 != 5'd0) && (32'(A3) < NREGS))
      regs_d[A3] = WD3;
  end

  always_ff @(posedge clk) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  always_comb begin
    rd1_raw = '0;
    rd2_raw = '0;
    if (32'(A1) < NREGS) rd1_raw = regs_q[A1];
    if (32'(A2) < NREGS) rd2_raw = regs_q[A2];
  end

`ifdef RF_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = WE3 && !reset && (A3 != 5'd0);
  assign RD1 = (fwd_ok && (A1 == A3)) ? WD3 : rd1_raw;
  assign RD2 = (fwd_ok && (A2 == A3)) ? WD3 : rd2_raw;
`else
  assign RD1 = rd1_raw;
  assign RD2 = rd2_raw;
`endif

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      2'b00:   ALUResult = RD1 + RD2;
      2'b01:   ALUResult = RD1 - RD2;
      2'b10:   ALUResult = RD1 & RD2;
      default: ALUResult = RD1 | RD2;
    endcase
  end

  assign Zero = (ALUResult == '0);

endmodule

// File: tb/tb_regfile_alu.sv
// Directed, table-driven bench for regfile_alu (both RF_BYPASS_EN builds).
module tb_regfile_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, A3;
  logic [31:0] WD3;
  logic        WE3;
  logic [31:0] RD1, RD2;
  logic [1:0]  ALUControl;
  logic [31:0] ALUResult;
  logic        Zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_alu dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3),
    .RD1(RD1), .RD2(RD2), .ALUControl(ALUControl), .ALUResult(ALUResult), .Zero(Zero)
  );

  typedef struct packed {
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [1:0]  ctl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  localparam int NV = 12;
  vec_t vec [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    A3 = a; WD3 = d; WE3 = 1'b1;
    @(posedge clk); #1;
    WE3 = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2, input logic [1:0] c);
    A1 = a1; A2 = a2; ALUControl = c;
    #1;
  endtask

  initial begin
    reset = 1'b1; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0; ALUControl = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset state: every entry reads zero.
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(i), 2'b00);
      check($sformatf("rst_rd1[%0d]", i), RD1, 32'h0);
      check($sformatf("rst_rd2[%0d]", i), RD2, 32'h0);
      check($sformatf("rst_res[%0d]", i), ALUResult, 32'h0);
      check($sformatf("rst_zero[%0d]", i), {31'h0, Zero}, 32'h1);
    end
    for (int c = 0; c < 4; c++) begin
      rd(5'd7, 5'd9, 2'(c));
      check($sformatf("rst_res_ctl%0d", c), ALUResult, 32'h0);
    end

    wr(5'd2, 32'd30);
    wr(5'd5, 32'hFFFF_FFFF);
    wr(5'd6, 32'd1);
    wr(5'd0, 32'h1234);

    vec[0]  = '{5'd2, 5'd2, 2'b10, 32'd30, 32'd30, 32'd30, 1'b0};
    vec[1]  = '{5'd2, 5'd2, 2'b00, 32'd30, 32'd30, 32'd60, 1'b0};
    vec[2]  = '{5'd2, 5'd2, 2'b01, 32'd30, 32'd30, 32'd0,  1'b1};
    vec[3]  = '{5'd2, 5'd2, 2'b11, 32'd30, 32'd30, 32'd30, 1'b0};
    vec[4]  = '{5'd5, 5'd6, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1};
    vec[5]  = '{5'd5, 5'd6, 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0};
    vec[6]  = '{5'd5, 5'd6, 2'b10, 32'hFFFF_FFFF, 32'd1, 32'h1, 1'b0};
    vec[7]  = '{5'd5, 5'd6, 2'b11, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0};
    vec[8]  = '{5'd6, 5'd5, 2'b01, 32'd1, 32'hFFFF_FFFF, 32'h2, 1'b0};
    vec[9]  = '{5'd0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1};
    vec[10] = '{5'd0, 5'd5, 2'b11, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vec[11] = '{5'd2, 5'd6, 2'b01, 32'd30, 32'd1, 32'd29, 1'b0};

    for (int i = 0; i < NV; i++) begin
      rd(vec[i].a1, vec[i].a2, vec[i].ctl);
      check($sformatf("v%0d_rd1", i), RD1, vec[i].rd1);
      check($sformatf("v%0d_rd2", i), RD2, vec[i].rd2);
      check($sformatf("v%0d_res", i), ALUResult, vec[i].res);
      check($sformatf("v%0d_zero", i), {31'h0, Zero}, {31'h0, vec[i].zero});
    end

    // Reset wins over a same-edge write, and clears earlier contents.
    wr(5'd3, 32'd7);
    rd(5'd3, 5'd2, 2'b00);
    check("x3_pre_rst", RD1, 32'd7);
    reset = 1'b1; A3 = 5'd3; WD3 = 32'd9; WE3 = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; WE3 = 1'b0;
    rd(5'd3, 5'd2, 2'b11);
    check("x3_after_rst", RD1, 32'h0);
    check("x2_after_rst", RD2, 32'h0);
    check("zero_after_rst", {31'h0, Zero}, 32'h1);

    // Read-during-write on x3 (old value 5), then x0 write attempt.
    wr(5'd3, 32'd5);
    rd(5'd3, 5'd3, 2'b00);
    A3 = 5'd3; WD3 = 32'd9; WE3 = 1'b1;
    #1;
`ifdef RF_BYPASS_EN
    check("rdw_rd1", RD1, 32'd9);
    check("rdw_rd2", RD2, 32'd9);
    check("rdw_res", ALUResult, 32'd18);
`else
    check("rdw_rd1", RD1, 32'd5);
    check("rdw_rd2", RD2, 32'd5);
    check("rdw_res", ALUResult, 32'd10);
`endif
    @(posedge clk); #1;
    WE3 = 1'b0;
    check("rdw_post_rd1", RD1, 32'd9);
    check("rdw_post_res", ALUResult, 32'd18);

    rd(5'd0, 5'd0, 2'b11);
    A3 = 5'd0; WD3 = 32'hDEAD_BEEF; WE3 = 1'b1;
    #1;
    check("x0_fwd_rd1", RD1, 32'h0);
    check("x0_fwd_zero", {31'h0, Zero}, 32'h1);
    @(posedge clk); #1;
    WE3 = 1'b0;
    check("x0_post_rd1", RD1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
